// File: rtl/test_serializer.sv
// ============================================================================
// Module   : test_serializer
// Purpose  : Parallel-to-serial transmitter, LSB first, with stall and last-bit
//            marker. Optional parity bit via TEST_SERIALIZER_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module test_serializer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         IN_valid,
  input  logic [N-1:0] IN_data,
  input  logic         IN_stall,
  output logic         OUT_ready,
  output logic         OUT_svalid,
  output logic         OUT_sdata,
  output logic         OUT_last
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

`ifdef TEST_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t           state_q;
  logic [N-1:0]     shreg_q;
  logic [CNT_W-1:0] cnt_q;
`ifdef TEST_SERIALIZER_PARITY_EN
  logic             par_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef TEST_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // Stall is deliberately ignored here: it only throttles shifting.
          if (IN_valid) begin
            shreg_q <= IN_data;
            cnt_q   <= '0;
            state_q <= SHIFT;
`ifdef TEST_SERIALIZER_PARITY_EN
            par_q   <= ^IN_data;
`endif
          end
        end
        SHIFT: begin
          if (!IN_stall) begin
            shreg_q <= shreg_q >> 1;
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
`ifdef TEST_SERIALIZER_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= IDLE;
`endif
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
`ifdef TEST_SERIALIZER_PARITY_EN
        PARITY: begin
          if (!IN_stall) begin
            state_q <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  // rst is the only input allowed to reach an output combinationally.
  assign OUT_ready  = (state_q == IDLE) && !rst;
  assign OUT_svalid = (state_q != IDLE);

`ifdef TEST_SERIALIZER_PARITY_EN
  assign OUT_sdata = (state_q == SHIFT)  ? shreg_q[0] :
                     (state_q == PARITY) ? par_q      : 1'b0;
  assign OUT_last  = (state_q == PARITY);
`else
  assign OUT_sdata = (state_q == SHIFT) && shreg_q[0];
  assign OUT_last  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
`endif

endmodule

`default_nettype wire

// File: tb/tb_test_serializer.sv
// ============================================================================
// Module   : tb_test_serializer
// Purpose  : Scoreboard bench for test_serializer (N=4); honours
//            TEST_SERIALIZER_PARITY_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_test_serializer;

  localparam int N = 4;
`ifdef TEST_SERIALIZER_PARITY_EN
  localparam int NB = N + 1;
`else
  localparam int NB = N;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         IN_valid = 1'b0;
  logic [N-1:0] IN_data = '0;
  logic         IN_stall = 1'b0;
  logic         OUT_ready;
  logic         OUT_svalid;
  logic         OUT_sdata;
  logic         OUT_last;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct packed {
    logic b;
    logic l;
  } exp_t;
  exp_t sb[$];

  test_serializer #(.N(N)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .IN_valid   (IN_valid),
    .IN_data    (IN_data),
    .IN_stall   (IN_stall),
    .OUT_ready  (OUT_ready),
    .OUT_svalid (OUT_svalid),
    .OUT_sdata  (OUT_sdata),
    .OUT_last   (OUT_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected serial bits are queued on accept and retired on unstalled edges.
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
    end else if (sb.size() == 0) begin
      if (IN_valid) begin
        for (int i = 0; i < N; i++) begin
`ifdef TEST_SERIALIZER_PARITY_EN
          sb.push_back('{b: IN_data[i], l: 1'b0});
`else
          sb.push_back('{b: IN_data[i], l: (i == N - 1)});
`endif
        end
`ifdef TEST_SERIALIZER_PARITY_EN
        sb.push_back('{b: ^IN_data, l: 1'b1});
`endif
      end
    end else if (!IN_stall) begin
      void'(sb.pop_front());
    end
  end

  always @(negedge clk) begin
    check("ready", {7'd0, OUT_ready}, {7'd0, (sb.size() == 0) && !rst});
    check("svalid", {7'd0, OUT_svalid}, {7'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      check("sdata", {7'd0, OUT_sdata}, {7'd0, sb[0].b});
      check("last", {7'd0, OUT_last}, {7'd0, sb[0].l});
    end else begin
      check("last_idle", {7'd0, OUT_last}, 8'd0);
      if (rst) check("sdata_rst", {7'd0, OUT_sdata}, 8'd0);
    end
  end

  task automatic step(input logic v, input logic [N-1:0] d, input logic s, input logic r);
    IN_valid = v;
    IN_data  = d;
    IN_stall = s;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget = 40;
    while (sb.size() != 0 && budget > 0) begin
      step(1'b0, N'($urandom), 1'b0, 1'b0);
      budget--;
    end
    if (sb.size() != 0) check("drain_timeout", 8'd1, 8'd0);
  endtask

  // One frame from accept through its final unstalled bit; junk data while busy.
  task automatic frame(input logic [N-1:0] d, input int stall_bit, input int stall_len,
                       input logic stall_on_accept);
    step(1'b1, d, stall_on_accept, 1'b0);
    for (int i = 0; i < NB; i++) begin
      if (i == stall_bit) repeat (stall_len) step(1'b0, N'($urandom), 1'b1, 1'b0);
      step(1'b0, N'($urandom), 1'b0, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;
    step(1'b1, 4'b1010, 1'b0, 1'b1);
    step(1'b1, 4'b1010, 1'b0, 1'b1);
    step(1'b0, 4'b0000, 1'b0, 1'b0);

    frame(4'b1011, -1, 0, 1'b0);
    drain();
    frame(4'b0110, 1, 2, 1'b0);
    drain();

    // Busy then back-to-back: second word held until ready returns.
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    repeat (NB) step(1'b1, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    repeat (NB) step(1'b0, 4'b0000, 1'b0, 1'b0);
    drain();

    // Reset during bit 1, then a clean frame right away.
    step(1'b1, 4'b1001, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 1'b1);
    frame(4'b0011, -1, 0, 1'b0);
    drain();

    frame(4'b1011, NB - 1, 2, 1'b1);
    drain();
    frame(4'b0110, -1, 0, 1'b0);
    drain();

    for (int t = 0; t < 10; t++) begin
      frame(N'($urandom), int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 2)),
            1'($urandom));
      drain();
    end
    step(1'b0, 4'b0000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
